// File: rtl/legv8_dp_pkg.sv
// Shared definitions for the parametrised LEGv8 datapath: control-word field
// offsets, ALU and PC-select encodings, FSM states and a clog2 helper.
package legv8_dp_pkg;

   // Control bits sit above the three register-select fields (DA, SA, SB);
   // offsets below are relative to bit 3*RW of the control word.
   localparam int CW_CTRL_W  = 15;
   localparam int OFS_FS     = 0;
   localparam int OFS_PS     = 5;
   localparam int OFS_WR     = 7;
   localparam int OFS_WM     = 8;
   localparam int OFS_SL     = 9;
   localparam int OFS_BSEL   = 10;
   localparam int OFS_PCSEL  = 11;
   localparam int OFS_EN_ALU = 12;
   localparam int OFS_EN_MEM = 13;
   localparam int OFS_EN_PC  = 14;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_XOR = 3'b011,
      OP_LSL = 3'b100,
      OP_LSR = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      PS_HOLD = 2'b00,
      PS_INC  = 2'b01,
      PS_REL  = 2'b10,
      PS_ABS  = 2'b11
   } pc_sel_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } dp_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/datapath_legv8_mw_alu.sv
// Combinational LEGv8 ALU: logic ops, add/sub with carry and overflow, shifts,
// and B pass-through. Flags are returned as {V, C, N, Z}.
module alu_legv8_n
   import legv8_dp_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [4:0]        i_fs,
   output logic [DATA_W-1:0] o_result,
   output logic [3:0]        o_flags
);

   localparam int SH_W = clog2(DATA_W);

   logic [DATA_W-1:0] w_a_op;
   logic [DATA_W-1:0] w_b_op;
   logic [DATA_W-1:0] w_sum;
   logic              w_cout;
   logic              w_c;
   logic              w_v;

   assign w_a_op = i_fs[1] ? ~i_a : i_a;
   assign w_b_op = i_fs[0] ? ~i_b : i_b;
   // FS[0] doubles as the carry-in so that FS=01001 yields A - B.
   assign {w_cout, w_sum} = {1'b0, w_a_op} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, i_fs[0]};

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      o_result = i_b;
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (alu_op_e'(i_fs[4:2]))
         OP_AND: o_result = w_a_op & w_b_op;
         OP_OR:  o_result = w_a_op | w_b_op;
         OP_ADD: begin
            o_result = w_sum;
            w_c      = w_cout;
            w_v      = (w_a_op[DATA_W-1] == w_b_op[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != w_a_op[DATA_W-1]);
         end
         OP_XOR: o_result = w_a_op ^ w_b_op;
         OP_LSL: o_result = i_a << i_b[SH_W-1:0];
         OP_LSR: o_result = i_a >> i_b[SH_W-1:0];
         default: o_result = i_b;
      endcase
   end

   assign o_flags = {w_v, w_c, o_result[DATA_W-1], (o_result == '0)};

endmodule

// File: rtl/datapath_legv8_mw.sv
// Multi-width LEGv8 datapath: register file, ALU, status flags, PC and a
// valid/ready control handshake with a req/ack data-memory port.
module datapath_legv8_mw
   import legv8_dp_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                REGS     = 32,
   parameter int                ADDR_W   = 8,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic [CW_CTRL_W+3*clog2(REGS)-1:0]  i_control_word,
   input  logic                                i_cw_valid,
   output logic                                o_cw_ready,
   input  logic [DATA_W-1:0]                   i_constant,
   output logic [4:0]                          o_status,
   output logic [DATA_W-1:0]                   o_pc,
   output logic                                o_mem_req,
   output logic                                o_mem_we,
   output logic [ADDR_W-1:0]                   o_mem_addr,
   output logic [DATA_W-1:0]                   o_mem_wdata,
   input  logic [DATA_W-1:0]                   i_mem_rdata,
   input  logic                                i_mem_ack,
   output logic                                o_bus_conflict
);

   localparam int RW = clog2(REGS);
   localparam int CB = 3 * RW;

   logic [RW-1:0] w_da, w_sa, w_sb;
   logic [4:0]    w_fs;
   logic [1:0]    w_ps;
   logic          w_wr, w_wm, w_sl, w_bsel, w_pcsel, w_en_alu, w_en_mem, w_en_pc;

   assign w_da     = i_control_word[RW-1:0];
   assign w_sa     = i_control_word[2*RW-1:RW];
   assign w_sb     = i_control_word[3*RW-1:2*RW];
   assign w_fs     = i_control_word[CB+OFS_FS +: 5];
   assign w_ps     = i_control_word[CB+OFS_PS +: 2];
   assign w_wr     = i_control_word[CB+OFS_WR];
   assign w_wm     = i_control_word[CB+OFS_WM];
   assign w_sl     = i_control_word[CB+OFS_SL];
   assign w_bsel   = i_control_word[CB+OFS_BSEL];
   assign w_pcsel  = i_control_word[CB+OFS_PCSEL];
   assign w_en_alu = i_control_word[CB+OFS_EN_ALU];
   assign w_en_mem = i_control_word[CB+OFS_EN_MEM];
   assign w_en_pc  = i_control_word[CB+OFS_EN_PC];

   logic [DATA_W-1:0] r_regs [REGS];
   logic [DATA_W-1:0] r_pc;
   logic [3:0]        r_flags;
   logic              r_conflict;
   dp_state_e         r_state, w_state_next;

   // Memory-word context captured at accept and applied when the ack arrives.
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_we;
   logic [RW-1:0]     r_da;
   logic              r_wb_en;
   logic              r_wb_from_mem;
   logic [DATA_W-1:0] r_wb_val;
   logic [DATA_W-1:0] r_pc_next;
   logic [3:0]        r_flags_new;
   logic              r_sl;

   logic [DATA_W-1:0] w_a, w_b, w_abus, w_bbus, w_alu_result, w_pc_inc, w_pc_target;
   logic [DATA_W-1:0] w_bus_local, w_rf_wdata;
   logic [3:0]        w_alu_flags;
   logic [1:0]        w_src_cnt;
   logic              w_one_src, w_multi_src, w_is_mem;
   logic              w_accept, w_mem_done, w_rf_we;
   logic [RW-1:0]     w_rf_waddr;

   // The top register (XZR) and any unimplemented index read as zero.
   assign w_a    = (int'(w_sa) >= REGS - 1) ? '0 : r_regs[w_sa];
   assign w_b    = (int'(w_sb) >= REGS - 1) ? '0 : r_regs[w_sb];
   assign w_abus = w_pcsel ? i_constant : w_a;
   assign w_bbus = w_bsel  ? i_constant : w_b;

   alu_legv8_n #(.DATA_W(DATA_W)) u_alu (
      .i_a      (w_abus),
      .i_b      (w_bbus),
      .i_fs     (w_fs),
      .o_result (w_alu_result),
      .o_flags  (w_alu_flags)
   );

   assign w_pc_inc    = r_pc + DATA_W'(4);
   assign w_src_cnt   = 2'(w_en_pc) + 2'(w_en_alu) + 2'(w_en_mem);
   assign w_one_src   = (w_src_cnt == 2'd1);
   assign w_multi_src = (w_src_cnt > 2'd1);
   assign w_is_mem    = w_en_mem | w_wm;
   assign w_bus_local = w_en_pc ? w_pc_inc : w_alu_result;

   always_comb begin
      w_pc_target = r_pc;
      case (pc_sel_e'(w_ps))
         PS_HOLD: w_pc_target = r_pc;
         PS_INC:  w_pc_target = w_pc_inc;
         PS_REL:  w_pc_target = r_pc + (w_abus << 2);
         PS_ABS:  w_pc_target = w_abus;
         default: w_pc_target = r_pc;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_mem_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_accept = i_cw_valid;
            if (i_cw_valid && w_is_mem) w_state_next = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            w_mem_done = i_mem_ack;
            if (i_mem_ack) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Non-memory words write at the accept edge; memory words at the ack edge.
   always_comb begin
      w_rf_we    = 1'b0;
      w_rf_waddr = w_da;
      w_rf_wdata = w_bus_local;
      if (w_accept && !w_is_mem) begin
         w_rf_we = w_wr & w_one_src;
      end else if (w_mem_done) begin
         w_rf_we    = r_wb_en;
         w_rf_waddr = r_da;
         w_rf_wdata = r_wb_from_mem ? i_mem_rdata : r_wb_val;
      end
   end

   // NOTE: the register array is cleared by reset, so it is built from
   // flops with a reset loop rather than mapped onto a RAM macro.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
      end else if (w_rf_we && (int'(w_rf_waddr) < REGS - 1)) begin
         r_regs[w_rf_waddr] <= w_rf_wdata;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_flags       <= '0;
         r_conflict    <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_we      <= 1'b0;
         r_da          <= '0;
         r_wb_en       <= 1'b0;
         r_wb_from_mem <= 1'b0;
         r_wb_val      <= '0;
         r_pc_next     <= '0;
         r_flags_new   <= '0;
         r_sl          <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            if (w_multi_src) r_conflict <= 1'b1;
            if (w_is_mem) begin
               r_mem_addr    <= w_alu_result[ADDR_W+2:3];
               r_mem_wdata   <= w_b;
               r_mem_we      <= w_wm;
               r_da          <= w_da;
               r_wb_en       <= w_wr & w_one_src;
               r_wb_from_mem <= w_en_mem;
               r_wb_val      <= w_bus_local;
               r_pc_next     <= w_pc_target;
               r_flags_new   <= w_alu_flags;
               r_sl          <= w_sl;
            end else begin
               r_pc <= w_pc_target;
               if (w_sl) r_flags <= w_alu_flags;
            end
         end
         if (w_mem_done) begin
            r_pc <= r_pc_next;
            if (r_sl) r_flags <= r_flags_new;
         end
      end
   end

   assign o_cw_ready     = (r_state == ST_IDLE) & ~i_reset;
   assign o_mem_req      = (r_state == ST_MEM_WAIT);
   assign o_mem_we       = r_mem_we & o_mem_req;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_pc           = r_pc;
   assign o_status       = {r_flags, w_alu_flags[0]};
   assign o_bus_conflict = r_conflict;

endmodule

// File: tb/tb_datapath_legv8_mw.sv
// Scoreboard bench for datapath_legv8_mw: directed LEGv8 sequences followed by
// random control words, checked against an architectural reference model.
module tb_datapath_legv8_mw;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] cw = '0;
   logic        cw_valid = 1'b0;
   logic        cw_ready;
   logic [63:0] konst = '0;
   logic [4:0]  status;
   logic [63:0] pc;
   logic        mem_req, mem_we, mem_ack = 1'b0, bus_conflict;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata, mem_rdata = '0;

   always #5 clk = ~clk;

   datapath_legv8_mw dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_control_word (cw),
      .i_cw_valid     (cw_valid),
      .o_cw_ready     (cw_ready),
      .i_constant     (konst),
      .o_status       (status),
      .o_pc           (pc),
      .o_mem_req      (mem_req),
      .o_mem_we       (mem_we),
      .o_mem_addr     (mem_addr),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (mem_rdata),
      .i_mem_ack      (mem_ack),
      .o_bus_conflict (bus_conflict)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural reference state.
   logic [63:0] m_regs [32];
   logic [63:0] m_pc;
   logic [3:0]  m_flags;
   logic        m_conflict;

   typedef struct { logic [63:0] pc; logic [4:0] status; logic conflict; } acc_t;
   typedef struct { logic [7:0] addr; logic [63:0] wdata; logic we; int cycles; } mem_t;
   acc_t q_acc[$];
   mem_t q_mem[$];

   localparam logic [4:0] FS_AND = 5'b00000, FS_ADD = 5'b01000, FS_SUB = 5'b01001;

   function automatic logic [29:0] mk_cw(input logic en_pc, input logic en_mem, input logic en_alu,
                                         input logic pcsel, input logic bsel, input logic sl,
                                         input logic wm, input logic wr, input logic [1:0] ps,
                                         input logic [4:0] fs, input logic [4:0] sb,
                                         input logic [4:0] sa, input logic [4:0] da);
      return {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
   endfunction

   function automatic logic [63:0] rd(input logic [4:0] r);
      return (r == 5'd31) ? 64'd0 : m_regs[r];
   endfunction

   // Returns {V, C, N, Z, result}; overflow judged from a sign-extended sum.
   function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs);
      logic [63:0] x, y, r;
      logic [65:0] s;
      logic        c, v;
      x = fs[1] ? ~a : a;
      y = fs[0] ? ~b : b;
      c = 1'b0;
      v = 1'b0;
      case (fs[4:2])
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: begin
            s = {x[63], x[63], x} + {y[63], y[63], y} + {65'd0, fs[0]};
            r = s[63:0];
            c = ({1'b0, x} + {1'b0, y} + {64'd0, fs[0]}) >> 64 != 65'd0;
            v = (s[64] != s[63]);
         end
         3'd3: r = x ^ y;
         3'd4: r = a << b[5:0];
         3'd5: r = a >> b[5:0];
         default: r = b;
      endcase
      return {v, c, r[63], (r == 64'd0), r};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc       = '0;
      m_flags    = '0;
      m_conflict = 1'b0;
   endtask

   // Issue one control word, serve its memory access, update the model.
   task automatic issue(input logic [29:0] c, input logic [63:0] k, input int wait_cyc,
                        input logic [63:0] rdata, input bit abort);
      logic [63:0] a, b, abus, bbus, res, npc, val;
      logic [67:0] alu;
      logic [3:0]  fl;
      int          nsrc, t;
      bit          is_mem;
      acc_t        e;
      a    = rd(c[9:5]);
      b    = rd(c[14:10]);
      abus = c[26] ? k : a;
      bbus = c[25] ? k : b;
      alu  = ref_alu(abus, bbus, c[19:15]);
      res  = alu[63:0];
      fl   = alu[67:64];
      e.pc = m_pc; e.status = {m_flags, fl[0]}; e.conflict = m_conflict;
      q_acc.push_back(e);
      nsrc   = int'(c[29]) + int'(c[28]) + int'(c[27]);
      is_mem = c[28] | c[23];
      case (c[21:20])
         2'b00:   npc = m_pc;
         2'b01:   npc = m_pc + 64'd4;
         2'b10:   npc = m_pc + abus * 64'd4;
         default: npc = abus;
      endcase
      if (is_mem) q_mem.push_back('{addr: res[10:3], wdata: b, we: c[23], cycles: wait_cyc});
      cw = c; konst = k; cw_valid = 1'b1;
      t = 0;
      while (!cw_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!cw_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: cw_ready stayed low for %0d cycles", t);
      end
      @(posedge clk); #1;
      cw_valid = 1'b0;
      if (nsrc > 1) m_conflict = 1'b1;
      if (is_mem && abort) begin
         @(posedge clk); #2;
         rst = 1'b1;
         #1;
         check("rst_wait_mem_req", mem_req, 0);
         check("rst_wait_pc", pc, 0);
         check("rst_wait_ready", cw_ready, 0);
         model_reset();
         @(posedge clk); #1;
         rst = 1'b0;
         #1;
         check("rst_release_ready", cw_ready, 1);
         return;
      end
      if (is_mem) begin
         repeat (wait_cyc - 1) @(posedge clk);
         #1;
         mem_ack = 1'b1; mem_rdata = rdata;
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
      end
      val = c[29] ? m_pc + 64'd4 : (c[27] ? res : rdata);
      if (c[22] && nsrc == 1 && c[4:0] != 5'd31) m_regs[c[4:0]] = val;
      m_pc = npc;
      if (c[24]) m_flags = fl;
   endtask

   // Idle cycles with stray acks, which the datapath must ignore while IDLE.
   task automatic idle(input int n);
      repeat (n) begin
         mem_ack   = ($urandom_range(0, 3) == 0);
         mem_rdata = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
   endtask

   // Monitor: compares architectural state at each accept and the memory port
   // at each request start, and checks request length when it drops.
   bit   prev_req = 1'b0;
   bit   have_cur = 1'b0;
   int   req_len  = 0;
   mem_t cur;
   acc_t ea;

   always @(negedge clk) begin
      if (rst) begin
         prev_req = 1'b0; req_len = 0; have_cur = 1'b0;
      end else begin
         if (cw_valid && cw_ready) begin
            if (q_acc.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL acc_unexpected: accept with no expectation queued");
            end else begin
               ea = q_acc.pop_front();
               check("acc_pc", pc, ea.pc);
               check("acc_status", {59'd0, status}, {59'd0, ea.status});
               check("acc_conflict", bus_conflict, ea.conflict);
            end
         end
         if (mem_req) begin
            check("ready_low_in_wait", cw_ready, 0);
            if (!prev_req) begin
               if (q_mem.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL mem_unexpected: request with no expectation queued");
               end else begin
                  cur = q_mem.pop_front();
                  have_cur = 1'b1;
                  req_len = 1;
                  check("mem_addr", {56'd0, mem_addr}, {56'd0, cur.addr});
                  check("mem_wdata", mem_wdata, cur.wdata);
                  check("mem_we", mem_we, cur.we);
               end
            end else begin
               req_len++;
            end
         end else if (prev_req && have_cur) begin
            check("mem_req_cycles", req_len, cur.cycles);
            have_cur = 1'b0;
         end
         prev_req = mem_req;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pc0;
      logic [29:0] c;
      logic [63:0] k;
      int          kind;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready_low", cw_ready, 0);
      rst = 1'b0;
      #1;
      check("rst_pc", pc, 0);
      check("rst_status", {60'd0, status[4:1]}, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", {56'd0, mem_addr}, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_conflict", bus_conflict, 0);
      check("rst_ready", cw_ready, 1);

      // R1 = 5, then R4 = R1 - 5 with status load.
      issue(mk_cw(0, 0, 1, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd1), 64'd5, 1, 0, 0);
      issue(mk_cw(0, 0, 1, 0, 1, 1, 0, 1, 2'b01, FS_SUB, 5'd0, 5'd1, 5'd4), 64'd5, 1, 0, 0);
      check("sub_flags_vcnz", {60'd0, status[4:1]}, 64'b0101);
      // R2 = 0xDEAD, store at 0x18 with three wait cycles.
      issue(mk_cw(0, 0, 1, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd2), 64'hDEAD, 1, 0, 0);
      issue(mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd2, 5'd31, 5'd0), 64'h18, 3, 0, 0);
      // Load 0x1234 into R3, read it back through a store; XZR stays zero.
      issue(mk_cw(0, 1, 0, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd3), 64'h20, 1, 64'h1234, 0);
      issue(mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd3, 5'd31, 5'd0), 64'h28, 2, 0, 0);
      issue(mk_cw(0, 1, 0, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd31), 64'h30, 1, 64'hBEEF, 0);
      issue(mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd31, 5'd31, 5'd0), 64'h38, 1, 0, 0);
      // Relative branch by constant 4 words.
      pc0 = m_pc;
      issue(mk_cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, FS_AND, 5'd0, 5'd0, 5'd0), 64'd4, 1, 0, 0);
      check("branch_rel_pc", pc, pc0 + 64'd16);
      // Two bus sources: no write to R1, sticky conflict.
      issue(mk_cw(0, 1, 1, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd1), 64'h40, 2, 64'h77, 0);
      check("conflict_set", bus_conflict, 1);
      issue(mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd1, 5'd31, 5'd0), 64'h48, 1, 0, 0);
      idle(3);
      // Reset during a load wait: nothing retires.
      issue(mk_cw(0, 1, 0, 0, 1, 0, 0, 1, 2'b01, FS_ADD, 5'd0, 5'd31, 5'd1), 64'h50, 3, 64'h99, 1);
      check("after_rst_conflict", bus_conflict, 0);
      issue(mk_cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b01, FS_ADD, 5'd1, 5'd31, 5'd0), 64'h58, 1, 0, 0);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         k = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
         c = mk_cw(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 1,
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom),
                   5'($urandom));
         case (kind)
            5: begin c[28] = 1'b1; c[27] = 1'b0; end
            6: begin c[23] = 1'b1; c[27] = 1'b0; c[22] = 1'b0; end
            7: begin c[27] = 1'b0; c[22] = 1'b0; end
            8: begin c[29] = 1'b1; c[27] = 1'b0; end
            9: c = 30'($urandom);
            default: ;
         endcase
         issue(c, k, $urandom_range(1, 4), {$urandom, $urandom}, 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
      check("acc_queue_drained", q_acc.size(), 0);
      check("mem_queue_drained", q_mem.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
